branch_resolve_queue: RTL and testbench
=======================================

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 Parameter LOWER, default 5: width of the branch history table index (PC low bits).
REQ-002 Parameter DEPTH, default 4, power of two, minimum 2: number of in-flight branch records.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 pred_valid  input  1  fetch presents one predicted branch record this cycle.
REQ-006 pred_idx  input  LOWER  table index used when the prediction was read.
REQ-007 pred_taken  input  1  direction predicted by the branch history table.
REQ-008 pred_ready  output  1  a record can be accepted this cycle.
REQ-009 res_valid  input  1  execute resolves the oldest outstanding branch this cycle.
REQ-010 res_taken  input  1  actual conditional outcome.
REQ-011 res_jump  input  1  branch was an unconditional jump.
REQ-012 flush  input  1  external pipeline flush, such as an exception.
REQ-013 upd_en, upd_addr[LOWER], upd_taken, upd_jumped  outputs  table update strobe, index and outcome for the branch history table.
REQ-014 mispredict  output  1  one-cycle pulse indicating a wrong direction prediction.
REQ-015 res_err  output  1  one-cycle pulse indicating a resolution arrived with no outstanding record.
REQ-016 count  output  clog2(DEPTH)+1  number of outstanding records.

Function
REQ-017 The queue SHALL be a circular FIFO with read and write pointers that wrap modulo DEPTH, storing {idx, taken} per entry.
REQ-018 A push SHALL occur when pred_valid and pred_ready are both high; pred_ready = (state==RUN) and (count<DEPTH), computed from current-cycle count only. A simultaneous pop while full does not enable a push.
REQ-019 A pop SHALL occur when res_valid is high and count>0. When res_valid is high and count==0, res_err pulses the next cycle and no pointer moves. This holds even if a push occurs in the same cycle.
REQ-020 Actual outcome = res_taken | res_jump; a pop is mispredicted when the actual outcome differs from the head entry's taken bit.
REQ-021 Latency: for a pop in cycle N, the following outputs SHALL be registered and valid in cycle N+1 for exactly one cycle:
- upd_en=1
- upd_addr = head idx
- upd_taken = res_taken
- upd_jumped = res_jump
- mispredict = the mispredict result
REQ-022 When no pop occurs, all upd_* outputs and mispredict SHALL be 0 in the next cycle.
REQ-023 FSM states RUN and RECOVER; reset state is RUN.
REQ-024 In RUN, a mispredicted pop SHALL transition the FSM to RECOVER.
REQ-025 In RECOVER, after exactly one cycle the FSM SHALL return to RUN; pred_ready=0 throughout RECOVER.
REQ-026 A mispredicted pop SHALL empty the queue, setting count to 0 and the read pointer equal to the write pointer in cycle N+1. Any push in cycle N is discarded as wrong-path.
REQ-027 Flush SHALL empty the queue in the next cycle and discard any same-cycle push.
REQ-028 A pop coincident with flush SHALL still produce its update and mispredict outputs.
REQ-029 Flush in RECOVER SHALL keep the FSM in RECOVER; flush does not itself enter RECOVER.
REQ-030 Resolutions in RECOVER SHALL be processed normally; with the queue empty, they raise res_err.
REQ-031 count SHALL equal pushes minus pops since the last empty event and never exceed DEPTH.

Reset
REQ-032 On rst=1 at a clock edge, the block SHALL set:
- pointers = 0, count = 0
- FSM = RUN
- upd_en, upd_addr, upd_taken, upd_jumped, mispredict, res_err = 0
- pred_ready = 1 in the cycle after rst deasserts
REQ-033 Reset asserted mid-operation SHALL discard all entries; any pop in that cycle produces no update.

Configuration
REQ-034 Macro BRQ_STATS_EN: when defined, add outputs stat_resolved[16] and stat_mispred[16].
- stat_resolved increments once per pop.
- stat_mispred increments once per mispredicted pop.
- Both saturate at 0xFFFF, are cleared by rst, and are unaffected by flush.
- When undefined, neither port nor counter exists and all other behaviour is identical.

Verification
REQ-035 Push idx 3,7,9 (taken 1,0,1); resolve 3 times with res_taken 1,0,1 -> upd_addr 3,7,9 on consecutive cycles, mispredict never set, count 3->0.
REQ-036 DEPTH=4: hold pred_valid 6 cycles with no resolution -> pred_ready drops after 4 pushes, count=4. A pop in the full cycle does not admit a push that cycle.
REQ-037 Push idx 5 (taken 0) and idx 6; resolve with res_taken=0, res_jump=1 -> next cycle: upd_addr=5, upd_jumped=1, mispredict=1, count=0, pred_ready=0 for one cycle, then 1.
REQ-038 res_valid with empty queue and a same-cycle push -> res_err=1 next cycle, count=1, no upd_en.
REQ-039 Queue holding 3 entries, flush with a simultaneous pop and push -> update emitted for the head, count=0, pushed record dropped.
REQ-040 With BRQ_STATS_EN: 10 pops including 4 mispredicts -> stat_resolved=10, stat_mispred=4. rst -> both 0.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-flight branch record FIFO with resolution, table update and recovery
// Optional counters enabled by macro BRQ_STATS_EN (adds stat_resolved / stat_mispred).
module branch_resolve_queue #(
   parameter int LOWER = 5,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pred_valid,
   input  logic [LOWER-1:0]         pred_idx,
   input  logic                     pred_taken,
   output logic                     pred_ready,
   input  logic                     res_valid,
   input  logic                     res_taken,
   input  logic                     res_jump,
   input  logic                     flush,
   output logic                     upd_en,
   output logic [LOWER-1:0]         upd_addr,
   output logic                     upd_taken,
   output logic                     upd_jumped,
   output logic                     mispredict,
   output logic                     res_err,
`ifdef BRQ_STATS_EN
   output logic [15:0]              stat_resolved,
   output logic [15:0]              stat_mispred,
`endif
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {RUN, RECOVER} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   logic [LOWER-1:0] idx_mem_q [DEPTH];
   logic             tkn_mem_q [DEPTH];

   logic             upd_en_q, upd_en_d;
   logic [LOWER-1:0] upd_addr_q, upd_addr_d;
   logic             upd_taken_q, upd_taken_d;
   logic             upd_jumped_q, upd_jumped_d;
   logic             mispredict_q, mispredict_d;
   logic             res_err_q, res_err_d;

   logic             push_w, pop_w, mis_w, empty_w;
   logic [LOWER-1:0] head_idx_w;
   logic             head_tkn_w;

   assign head_idx_w = idx_mem_q[rd_ptr_q];
   assign head_tkn_w = tkn_mem_q[rd_ptr_q];
   assign pred_ready = (state_q == RUN) && (count_q < FULL);
   assign push_w     = pred_valid && pred_ready;
   assign pop_w      = res_valid && (count_q != '0);
   assign mis_w      = pop_w && ((res_taken | res_jump) != head_tkn_w);
   // A mispredict or flush drops everything still queued, including this cycle's push.
   assign empty_w    = flush || mis_w;

   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      upd_en_d     = pop_w;
      upd_addr_d   = '0;
      upd_taken_d  = 1'b0;
      upd_jumped_d = 1'b0;
      mispredict_d = mis_w;
      res_err_d    = res_valid && (count_q == '0);
      if (pop_w) begin
         upd_addr_d   = head_idx_w;
         upd_taken_d  = res_taken;
         upd_jumped_d = res_jump;
      end
      if (empty_w) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (pop_w)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push_w) wr_ptr_d = wr_ptr_q + 1'b1;
         count_d = count_q + {{(CW-1){1'b0}}, push_w} - {{(CW-1){1'b0}}, pop_w};
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (mis_w) state_d = RECOVER;
         RECOVER: if (!flush) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         upd_en_q     <= 1'b0;
         upd_addr_q   <= '0;
         upd_taken_q  <= 1'b0;
         upd_jumped_q <= 1'b0;
         mispredict_q <= 1'b0;
         res_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         upd_en_q     <= upd_en_d;
         upd_addr_q   <= upd_addr_d;
         upd_taken_q  <= upd_taken_d;
         upd_jumped_q <= upd_jumped_d;
         mispredict_q <= mispredict_d;
         res_err_q    <= res_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_w && !empty_w && !rst) begin
         idx_mem_q[wr_ptr_q] <= pred_idx;
         tkn_mem_q[wr_ptr_q] <= pred_taken;
      end
   end

`ifdef BRQ_STATS_EN
   logic [15:0] stat_resolved_q, stat_mispred_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_resolved_q <= '0;
         stat_mispred_q  <= '0;
      end else begin
         if (pop_w && stat_resolved_q != 16'hFFFF) stat_resolved_q <= stat_resolved_q + 16'd1;
         if (mis_w && stat_mispred_q != 16'hFFFF)  stat_mispred_q  <= stat_mispred_q + 16'd1;
      end
   end

   assign stat_resolved = stat_resolved_q;
   assign stat_mispred  = stat_mispred_q;
`endif

   assign upd_en     = upd_en_q;
   assign upd_addr   = upd_addr_q;
   assign upd_taken  = upd_taken_q;
   assign upd_jumped = upd_jumped_q;
   assign mispredict = mispredict_q;
   assign res_err    = res_err_q;
   assign count      = count_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - directed bench with queue-based reference model for branch_resolve_queue
module tb_branch_resolve_queue;
   localparam int LOWER = 5;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst, pred_valid, pred_taken, pred_ready;
   logic [LOWER-1:0] pred_idx;
   logic res_valid, res_taken, res_jump, flush;
   logic upd_en, upd_taken, upd_jumped, mispredict, res_err;
   logic [LOWER-1:0] upd_addr;
   logic [$clog2(DEPTH):0] count;
`ifdef BRQ_STATS_EN
   logic [15:0] stat_resolved, stat_mispred;
`endif

   always #5 clk = ~clk;

   branch_resolve_queue #(.LOWER(LOWER), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .pred_valid(pred_valid), .pred_idx(pred_idx), .pred_taken(pred_taken), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_jump(res_jump), .flush(flush),
      .upd_en(upd_en), .upd_addr(upd_addr), .upd_taken(upd_taken), .upd_jumped(upd_jumped),
      .mispredict(mispredict), .res_err(res_err),
`ifdef BRQ_STATS_EN
      .stat_resolved(stat_resolved), .stat_mispred(stat_mispred),
`endif
      .count(count)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: list of outstanding records plus a recovering flag.
   typedef struct { int idx; bit taken; } rec_t;
   rec_t m_q[$];
   bit   m_rec = 0;
   bit   m_ok  = 0;
   bit   e_upd_en, e_upd_taken, e_upd_jumped, e_mis, e_err;
   int   e_upd_addr;
   int   m_resolved, m_mispred;

   always @(posedge clk) begin
      if (rst) begin
         m_q.delete(); m_rec = 0; m_ok = 1;
         {e_upd_en, e_upd_taken, e_upd_jumped, e_mis, e_err} = '0;
         e_upd_addr = 0; m_resolved = 0; m_mispred = 0;
      end else if (m_ok) begin
         bit rdy, psh, pp, mis;
         rdy = !m_rec && (m_q.size() < DEPTH);
         psh = pred_valid && rdy;
         pp  = res_valid && (m_q.size() > 0);
         mis = pp && ((res_taken || res_jump) != m_q[0].taken);
         e_err = res_valid && (m_q.size() == 0);
         e_upd_en = pp;
         e_upd_addr = pp ? m_q[0].idx : 0;
         e_upd_taken = pp && res_taken;
         e_upd_jumped = pp && res_jump;
         e_mis = mis;
         if (pp && m_resolved < 65535) m_resolved++;
         if (mis && m_mispred < 65535) m_mispred++;
         if (flush || mis) m_q.delete();
         else begin
            if (pp) void'(m_q.pop_front());
            if (psh) m_q.push_back('{idx: int'(pred_idx), taken: pred_taken});
         end
         m_rec = mis || (m_rec && flush);
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("pred_ready", pred_ready, (!m_rec && m_q.size() < DEPTH));
         chk("count", count, m_q.size());
         chk("upd_en", upd_en, e_upd_en);
         chk("upd_addr", upd_addr, e_upd_addr);
         chk("upd_taken", upd_taken, e_upd_taken);
         chk("upd_jumped", upd_jumped, e_upd_jumped);
         chk("mispredict", mispredict, e_mis);
         chk("res_err", res_err, e_err);
`ifdef BRQ_STATS_EN
         chk("stat_resolved", stat_resolved, m_resolved);
         chk("stat_mispred", stat_mispred, m_mispred);
`endif
      end
   end

   task automatic tick(input bit pv, input int pi, input bit pt,
                       input bit rv, input bit rt, input bit rj, input bit fl, input bit r);
      pred_valid = pv; pred_idx = LOWER'(pi); pred_taken = pt;
      res_valid = rv; res_taken = rt; res_jump = rj; flush = fl; rst = r;
      @(posedge clk); #1;
      {pred_valid, pred_taken, res_valid, res_taken, res_jump, flush, rst} = '0;
      pred_idx = '0;
   endtask

   task automatic push(input int i, input bit t);  tick(1, i, t, 0, 0, 0, 0, 0); endtask
   task automatic res(input bit t, input bit j);   tick(0, 0, 0, 1, t, j, 0, 0); endtask
   task automatic idle();                          tick(0, 0, 0, 0, 0, 0, 0, 0); endtask

   initial begin
      {pred_valid, pred_taken, res_valid, res_taken, res_jump, flush} = '0;
      pred_idx = '0; rst = 1'b1;
      #1;
      tick(0, 0, 0, 0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0, 0, 0, 1);
      chk("reset count", count, 0);
      chk("reset ready", pred_ready, 1);
      chk("reset upd_en", upd_en, 0);

      // in-order resolution, all correct
      push(3, 1); push(7, 0); push(9, 1);
      chk("three pushed", count, 3);
      res(1, 0); chk("res1 addr", upd_addr, 3); chk("res1 mis", mispredict, 0);
      res(0, 0); chk("res2 addr", upd_addr, 7); chk("res2 mis", mispredict, 0);
      res(1, 0); chk("res3 addr", upd_addr, 9); chk("drained", count, 0);

      // fill to DEPTH, hold pred_valid
      for (int i = 0; i < 6; i++) push(10 + i, 1);
      chk("full count", count, 4);
      chk("full ready", pred_ready, 0);
      tick(1, 20, 1, 1, 1, 0, 0, 0);
      chk("pop on full no push", count, 3);
      chk("pop on full addr", upd_addr, 10);
      for (int i = 0; i < 3; i++) res(1, 0);

      // jump mispredict empties queue and recovers one cycle
      push(5, 0); push(6, 1);
      res(0, 1);
      chk("jmp addr", upd_addr, 5); chk("jmp jumped", upd_jumped, 1);
      chk("jmp mis", mispredict, 1); chk("jmp count", count, 0);
      chk("recover ready", pred_ready, 0);
      idle();
      chk("after recover ready", pred_ready, 1);

      // resolution on empty queue with same-cycle push
      tick(1, 2, 0, 1, 0, 0, 0, 0);
      chk("err pulse", res_err, 1); chk("err count", count, 1); chk("err no upd", upd_en, 0);
      res(0, 0);

      // flush with simultaneous pop and push
      push(1, 0); push(2, 0); push(3, 0);
      tick(1, 4, 1, 1, 0, 0, 1, 0);
      chk("flush upd_en", upd_en, 1); chk("flush addr", upd_addr, 1);
      chk("flush count", count, 0);
      idle();

      // flush while recovering extends recovery
      push(8, 1); res(0, 0);
      chk("mis2", mispredict, 1);
      tick(1, 9, 1, 0, 0, 0, 1, 0);
      chk("flush in recover ready", pred_ready, 0);
      idle();
      chk("recover exit", pred_ready, 1);
      res(1, 0);
      chk("empty res err", res_err, 1);

      // reset mid-operation with pop
      push(12, 1); push(13, 1);
      tick(0, 0, 0, 1, 1, 0, 0, 1);
      chk("rst no upd", upd_en, 0); chk("rst count", count, 0);

`ifdef BRQ_STATS_EN
      for (int i = 0; i < 10; i++) begin
         push(i, 1);
         res(i < 4 ? 1'b0 : 1'b1, 0);
         idle();
      end
      chk("stat_resolved 10", stat_resolved, 10);
      chk("stat_mispred 4", stat_mispred, 4);
      tick(0, 0, 0, 0, 0, 0, 0, 1);
      chk("stat_resolved rst", stat_resolved, 0);
      chk("stat_mispred rst", stat_mispred, 0);
`endif

      // random mix against the model
      for (int i = 0; i < 300; i++)
         tick($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);

      idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
